// File: rtl/hazard_scoreboard.sv
// GRF write-side hazard scoreboard: tracks E/M/W destination slots with Tnew and
// answers D-stage reads with stall + forward select. Optional MDU stall via SB_MDU_STALL_EN.
module hazard_scoreboard #(
   parameter int ADDR_W = 5,
   parameter int TNEW_W = 2
) (
   input  logic              clk,
   input  logic              reset,
`ifdef SB_MDU_STALL_EN
   input  logic              mdu_busy,
   input  logic              d_is_md,
`endif
   input  logic              d_valid,
   input  logic [ADDR_W-1:0] d_wa,
   input  logic [TNEW_W-1:0] d_tnew,
   input  logic [ADDR_W-1:0] d_rs,
   input  logic              d_rs_used,
   input  logic [TNEW_W-1:0] d_rs_tuse,
   input  logic [ADDR_W-1:0] d_rt,
   input  logic              d_rt_used,
   input  logic [TNEW_W-1:0] d_rt_tuse,
   input  logic              flush,
   output logic              stall,
   output logic [1:0]        rs_fwd_sel,
   output logic [1:0]        rt_fwd_sel,
   output logic              w_valid,
   output logic [ADDR_W-1:0] w_wa
);

   localparam logic [TNEW_W-1:0] TNEW_ONE = 1;

   logic              e_valid_q, m_valid_q, w_valid_q;
   logic [ADDR_W-1:0] e_wa_q, m_wa_q, w_wa_q;
   logic [TNEW_W-1:0] e_tnew_q, m_tnew_q, w_tnew_q;

   logic              e_valid_d;
   logic [ADDR_W-1:0] e_wa_d;
   logic [TNEW_W-1:0] e_tnew_d;

   logic [2:0]        rs_res, rt_res;
   logic              stall_raw;
   logic              mdu_stall;

   function automatic logic [TNEW_W-1:0] dec_sat(input logic [TNEW_W-1:0] t);
      return (t == '0) ? '0 : t - TNEW_ONE;
   endfunction

   // Returns {stall, fwd_sel}; only the nearest matching slot is considered.
   function automatic logic [2:0] resolve(input logic [ADDR_W-1:0] ra,
                                          input logic              used,
                                          input logic [TNEW_W-1:0] tuse);
      logic [2:0] r;
      r = '0;
      if (used && (ra != '0)) begin
         if (e_valid_q && (e_wa_q == ra)) begin
            r = {e_tnew_q > tuse, (e_tnew_q == '0) ? 2'b10 : 2'b00};
         end else if (m_valid_q && (m_wa_q == ra)) begin
            r = {m_tnew_q > tuse, (m_tnew_q == '0) ? 2'b01 : 2'b00};
         end else if (w_valid_q && (w_wa_q == ra)) begin
            r = {w_tnew_q > tuse, 2'b00};
         end
      end
      return r;
   endfunction

`ifdef SB_MDU_STALL_EN
   assign mdu_stall = mdu_busy & d_is_md;
`else
   assign mdu_stall = 1'b0;
`endif

   always_comb begin
      rs_res     = resolve(d_rs, d_rs_used, d_rs_tuse);
      rt_res     = resolve(d_rt, d_rt_used, d_rt_tuse);
      stall_raw  = rs_res[2] | rt_res[2] | mdu_stall;
      stall      = 1'b0;
      rs_fwd_sel = 2'b00;
      rt_fwd_sel = 2'b00;
      if (!reset) begin
         stall      = stall_raw;
         rs_fwd_sel = rs_res[1:0];
         rt_fwd_sel = rt_res[1:0];
      end
   end

   // A stalled or flushed D instruction becomes an all-zero bubble in E.
   always_comb begin
      e_valid_d = 1'b0;
      e_wa_d    = '0;
      e_tnew_d  = '0;
      if (!(stall || flush)) begin
         e_valid_d = d_valid & (d_wa != '0);
         e_wa_d    = d_wa;
         e_tnew_d  = d_tnew;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_valid_q <= 1'b0;
         e_wa_q    <= '0;
         e_tnew_q  <= '0;
         m_valid_q <= 1'b0;
         m_wa_q    <= '0;
         m_tnew_q  <= '0;
         w_valid_q <= 1'b0;
         w_wa_q    <= '0;
         w_tnew_q  <= '0;
      end else begin
         w_valid_q <= m_valid_q;
         w_wa_q    <= m_wa_q;
         w_tnew_q  <= dec_sat(m_tnew_q);
         m_valid_q <= e_valid_q;
         m_wa_q    <= e_wa_q;
         m_tnew_q  <= dec_sat(e_tnew_q);
         e_valid_q <= e_valid_d;
         e_wa_q    <= e_wa_d;
         e_tnew_q  <= e_tnew_d;
      end
   end

   assign w_valid = w_valid_q;
   assign w_wa    = w_wa_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard; inputs change 1 ns after posedge,
// outputs are checked 1 ns later, well away from the next edge.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       d_valid, d_rs_used, d_rt_used, flush;
   logic [4:0] d_wa, d_rs, d_rt;
   logic [1:0] d_tnew, d_rs_tuse, d_rt_tuse;
   logic       stall, w_valid;
   logic [1:0] rs_fwd_sel, rt_fwd_sel;
   logic [4:0] w_wa;
`ifdef SB_MDU_STALL_EN
   logic       mdu_busy, d_is_md;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   hazard_scoreboard #(.ADDR_W(5), .TNEW_W(2)) dut (
      .clk(clk),
      .reset(reset),
`ifdef SB_MDU_STALL_EN
      .mdu_busy(mdu_busy),
      .d_is_md(d_is_md),
`endif
      .d_valid(d_valid),
      .d_wa(d_wa),
      .d_tnew(d_tnew),
      .d_rs(d_rs),
      .d_rs_used(d_rs_used),
      .d_rs_tuse(d_rs_tuse),
      .d_rt(d_rt),
      .d_rt_used(d_rt_used),
      .d_rt_tuse(d_rt_tuse),
      .flush(flush),
      .stall(stall),
      .rs_fwd_sel(rs_fwd_sel),
      .rt_fwd_sel(rt_fwd_sel),
      .w_valid(w_valid),
      .w_wa(w_wa)
   );

   always #5 clk = ~clk;

   task automatic idle();
      d_valid = 0; d_wa = 0; d_tnew = 0;
      d_rs = 0; d_rs_used = 0; d_rs_tuse = 0;
      d_rt = 0; d_rt_used = 0; d_rt_tuse = 0;
      flush = 0;
`ifdef SB_MDU_STALL_EN
      mdu_busy = 0; d_is_md = 0;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic drive_wr(input logic [4:0] wa, input logic [1:0] tn);
      d_valid = 1; d_wa = wa; d_tnew = tn;
   endtask

   task automatic drive_rs(input logic [4:0] ra, input logic [1:0] tuse);
      d_rs = ra; d_rs_used = 1; d_rs_tuse = tuse;
   endtask

   task automatic drive_rt(input logic [4:0] ra, input logic [1:0] tuse);
      d_rt = ra; d_rt_used = 1; d_rt_tuse = tuse;
   endtask

   task automatic drain();
      repeat (3) tick();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         tick();
         d_valid = 1'($urandom); d_wa = 5'($urandom); d_tnew = 2'($urandom);
         d_rs = 5'($urandom); d_rs_used = 1'b1; d_rs_tuse = 2'($urandom);
         d_rt = 5'($urandom); d_rt_used = 1'b1; d_rt_tuse = 2'($urandom);
         #1;
         n_checks++;
         if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", stall); end
         n_checks++;
         if (rs_fwd_sel !== 2'b00 || rt_fwd_sel !== 2'b00) begin
            n_fail++; $display("FAIL reset_fwd: got rs=%0b rt=%0b expected 00/00", rs_fwd_sel, rt_fwd_sel);
         end
         n_checks++;
         if (w_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %0b expected 0", w_valid); end
      end
      tick();
      reset = 1'b0;
      #1;
      n_checks++;
      if (stall !== 1'b0 || rs_fwd_sel !== 2'b00 || rt_fwd_sel !== 2'b00 || w_valid !== 1'b0 || w_wa !== 5'd0) begin
         n_fail++;
         $display("FAIL post_reset: got stall=%0b rs=%0b rt=%0b wv=%0b wa=%0d expected all 0",
                  stall, rs_fwd_sel, rt_fwd_sel, w_valid, w_wa);
      end
   endtask

   task automatic test_alu_fwd();
      tick(); drive_wr(5'd8, 2'd1);
      tick(); drive_rs(5'd8, 2'd1); #1;
      n_checks++;
      if (stall !== 1'b0 || rs_fwd_sel !== 2'b00) begin
         n_fail++; $display("FAIL alu_e: got stall=%0b rs=%0b expected 0/00", stall, rs_fwd_sel);
      end
      tick(); drive_rs(5'd8, 2'd1); #1;
      n_checks++;
      if (stall !== 1'b0 || rs_fwd_sel !== 2'b01) begin
         n_fail++; $display("FAIL alu_m: got stall=%0b rs=%0b expected 0/01", stall, rs_fwd_sel);
      end
      drain();
   endtask

   task automatic test_load_use();
      tick(); drive_wr(5'd9, 2'd2);
      tick(); drive_wr(5'd10, 2'd1); drive_rt(5'd9, 2'd0); #1;
      n_checks++;
      if (stall !== 1'b1 || rt_fwd_sel !== 2'b00) begin
         n_fail++; $display("FAIL load_c1: got stall=%0b rt=%0b expected 1/00", stall, rt_fwd_sel);
      end
      tick(); drive_wr(5'd10, 2'd1); drive_rt(5'd9, 2'd0); #1;
      n_checks++;
      if (stall !== 1'b1 || rt_fwd_sel !== 2'b00) begin
         n_fail++; $display("FAIL load_c2: got stall=%0b rt=%0b expected 1/00", stall, rt_fwd_sel);
      end
      tick(); drive_wr(5'd10, 2'd1); drive_rt(5'd9, 2'd0); #1;
      n_checks++;
      if (stall !== 1'b0 || rt_fwd_sel !== 2'b00) begin
         n_fail++; $display("FAIL load_c3: got stall=%0b rt=%0b expected 0/00", stall, rt_fwd_sel);
      end
      n_checks++;
      if (w_valid !== 1'b1 || w_wa !== 5'd9) begin
         n_fail++; $display("FAIL load_w: got wv=%0b wa=%0d expected 1/9", w_valid, w_wa);
      end
      tick(); #1;
      n_checks++;
      if (w_valid !== 1'b0) begin n_fail++; $display("FAIL load_bubble: got wv=%0b expected 0", w_valid); end
      tick(); tick(); #1;
      n_checks++;
      if (w_valid !== 1'b1 || w_wa !== 5'd10) begin
         n_fail++; $display("FAIL load_consumer_w: got wv=%0b wa=%0d expected 1/10", w_valid, w_wa);
      end
      drain();
   endtask

   task automatic test_zero_reg();
      tick(); drive_wr(5'd0, 2'd1);
      tick(); drive_rs(5'd0, 2'd0); #1;
      n_checks++;
      if (stall !== 1'b0 || rs_fwd_sel !== 2'b00) begin
         n_fail++; $display("FAIL zero_read: got stall=%0b rs=%0b expected 0/00", stall, rs_fwd_sel);
      end
      tick(); tick(); #1;
      n_checks++;
      if (w_valid !== 1'b0) begin n_fail++; $display("FAIL zero_w: got wv=%0b expected 0", w_valid); end
      drain();
   endtask

   task automatic test_shadow();
      tick(); drive_wr(5'd5, 2'd0);
      tick(); drive_wr(5'd5, 2'd1);
      tick(); drive_rs(5'd5, 2'd0); #1;
      n_checks++;
      if (stall !== 1'b1 || rs_fwd_sel !== 2'b00) begin
         n_fail++; $display("FAIL shadow_c1: got stall=%0b rs=%0b expected 1/00", stall, rs_fwd_sel);
      end
      tick(); drive_rs(5'd5, 2'd0); #1;
      n_checks++;
      if (stall !== 1'b0 || rs_fwd_sel !== 2'b01) begin
         n_fail++; $display("FAIL shadow_c2: got stall=%0b rs=%0b expected 0/01", stall, rs_fwd_sel);
      end
      drain();
   endtask

   task automatic test_jal_sat();
      tick(); drive_wr(5'd6, 2'd0);
      tick(); drive_rs(5'd6, 2'd0); drive_rt(5'd6, 2'd2); #1;
      n_checks++;
      if (stall !== 1'b0 || rs_fwd_sel !== 2'b10 || rt_fwd_sel !== 2'b10) begin
         n_fail++; $display("FAIL jal_e: got stall=%0b rs=%0b rt=%0b expected 0/10/10", stall, rs_fwd_sel, rt_fwd_sel);
      end
      tick(); drive_rs(5'd6, 2'd0); #1;
      n_checks++;
      if (stall !== 1'b0 || rs_fwd_sel !== 2'b01) begin
         n_fail++; $display("FAIL jal_m_sat: got stall=%0b rs=%0b expected 0/01", stall, rs_fwd_sel);
      end
      tick(); drive_rs(5'd6, 2'd0); #1;
      n_checks++;
      if (stall !== 1'b0 || rs_fwd_sel !== 2'b00 || w_valid !== 1'b1 || w_wa !== 5'd6) begin
         n_fail++; $display("FAIL jal_w: got stall=%0b rs=%0b wv=%0b wa=%0d expected 0/00/1/6",
                            stall, rs_fwd_sel, w_valid, w_wa);
      end
      drain();
   endtask

   task automatic test_flush();
      tick(); drive_wr(5'd3, 2'd1); flush = 1'b1;
      tick(); drive_rs(5'd3, 2'd0); drive_rt(5'd3, 2'd0); #1;
      n_checks++;
      if (stall !== 1'b0 || rs_fwd_sel !== 2'b00 || rt_fwd_sel !== 2'b00) begin
         n_fail++; $display("FAIL flush: got stall=%0b rs=%0b rt=%0b expected 0/00/00", stall, rs_fwd_sel, rt_fwd_sel);
      end
      drain();
   endtask

   task automatic test_unused();
      tick(); drive_wr(5'd7, 2'd2);
      tick(); drive_rs(5'd7, 2'd0); d_rs_used = 1'b0; drive_rt(5'd7, 2'd2); #1;
      n_checks++;
      if (stall !== 1'b0 || rs_fwd_sel !== 2'b00 || rt_fwd_sel !== 2'b00) begin
         n_fail++; $display("FAIL unused_tuse_eq: got stall=%0b rs=%0b rt=%0b expected 0/00/00", stall, rs_fwd_sel, rt_fwd_sel);
      end
      tick(); drive_rs(5'd7, 2'd0); #1;
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL used_m_stall: got stall=%0b expected 1", stall); end
      drain();
   endtask

   task automatic test_reset_during_stall();
      tick(); drive_wr(5'd11, 2'd2);
      tick(); drive_rs(5'd11, 2'd0); reset = 1'b1; #1;
      n_checks++;
      if (stall !== 1'b0 || rs_fwd_sel !== 2'b00) begin
         n_fail++; $display("FAIL reset_forces: got stall=%0b rs=%0b expected 0/00", stall, rs_fwd_sel);
      end
      tick(); reset = 1'b0; drive_rs(5'd11, 2'd0); #1;
      n_checks++;
      if (stall !== 1'b0 || rs_fwd_sel !== 2'b00) begin
         n_fail++; $display("FAIL reset_clears: got stall=%0b rs=%0b expected 0/00", stall, rs_fwd_sel);
      end
      drain();
   endtask

`ifdef SB_MDU_STALL_EN
   task automatic test_mdu();
      for (int i = 0; i < 5; i++) begin
         tick(); mdu_busy = 1'b1; d_is_md = 1'b1; #1;
         n_checks++;
         if (stall !== 1'b1) begin n_fail++; $display("FAIL mdu_busy_%0d: got stall=%0b expected 1", i, stall); end
      end
      tick(); mdu_busy = 1'b1; #1;
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL mdu_not_md: got stall=%0b expected 0", stall); end
      drain();
   endtask
`endif

   initial begin
      idle();
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_zero_reg();
      test_shadow();
      test_jal_sat();
      test_flush();
      test_unused();
      test_reset_during_stall();
`ifdef SB_MDU_STALL_EN
      test_mdu();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
